rect_draw_clip: RTL and testbench

RECT_DRAW_CLIP -- requirements
Module: rect_draw_clip

---
 rtl/rect_draw_clip_if.sv | 39 +++
 rtl/rect_draw_clip.sv | 156 +++++++++++++++
 tb/tb_rect_draw_clip.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rect_draw_clip_if.sv
// Rectangle rasteriser bus: draw request in, pixel stream and status out.
// The master side drives requests and pixel_ready; the slave side is the engine.
interface rect_draw_clip_if #(
  parameter int CW   = 8,
  parameter int COLW = 24
);
  logic            start;
  logic [CW-1:0]   x0;
  logic [CW-1:0]   y0;
  logic [CW-1:0]   x1;
  logic [CW-1:0]   y1;
  logic            fill_enable;
  logic [3:0]      thick;
  logic [COLW-1:0] color;
  logic            pixel_ready;
  logic [CW-1:0]   px;
  logic [CW-1:0]   py;
  logic [COLW-1:0] pixel_color;
  logic            pixel_valid;
  logic            busy;
  logic            done;
  logic            clipped;

  modport master (
    output start, x0, y0, x1, y1,
    output fill_enable, thick, color,
    output pixel_ready,
    input  px, py, pixel_color, pixel_valid,
    input  busy, done, clipped
  );

  modport slave (
    input  start, x0, y0, x1, y1,
    input  fill_enable, thick, color,
    input  pixel_ready,
    output px, py, pixel_color, pixel_valid,
    output busy, done, clipped
  );
endinterface

// File: rtl/rect_draw_clip.sv
// Filled/outlined rectangle rasteriser with screen clipping.
// Emits one pixel per cycle in row-major order over a valid/ready stream.
module rect_draw_clip #(
  parameter int CW    = 8,
  parameter int COLW  = 24,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input logic             clk,
  input logic             rst_n,
  rect_draw_clip_if.slave bus
);
  localparam int W = CW + 1;
  typedef logic [W-1:0] crd_t;
  localparam crd_t XLIM = crd_t'(SCR_W - 1);
  localparam crd_t YLIM = crd_t'(SCR_H - 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, DRAW, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] rx0, ry0, rx1, ry1;
  logic [3:0]    r_thick;
  logic          r_fill;

  crd_t xmin_q, xmax_q, ymin_q, ymax_q;
  crd_t cxmax_q, cymax_q, t_q;

  crd_t s_xmin, s_xmax, s_ymin, s_ymax;
  crd_t s_cx, s_cy, s_t;
  logic s_off, s_clip;

  always_comb begin
    s_xmin = (rx0 < rx1) ? {1'b0, rx0} : {1'b0, rx1};
    s_xmax = (rx0 < rx1) ? {1'b0, rx1} : {1'b0, rx0};
    s_ymin = (ry0 < ry1) ? {1'b0, ry0} : {1'b0, ry1};
    s_ymax = (ry0 < ry1) ? {1'b0, ry1} : {1'b0, ry0};
    s_cx   = (s_xmax > XLIM) ? XLIM : s_xmax;
    s_cy   = (s_ymax > YLIM) ? YLIM : s_ymax;
    s_t    = (r_thick == 4'd0) ? crd_t'(1) : crd_t'(r_thick);
    s_off  = (s_xmin > XLIM) || (s_ymin > YLIM);
    s_clip = (s_xmax > XLIM) || (s_ymax > YLIM);
  end

  crd_t cx, cy, nx, ny, cand;
  logic row_full, x_inner, row_cont, last, xfer;

  // Interior rows jump straight from the left band to the right band.
  always_comb begin
    cx       = {1'b0, bus.px};
    cy       = {1'b0, bus.py};
    nx       = cx + crd_t'(1);
    ny       = cy + crd_t'(1);
    row_full = r_fill
            || (cy < ymin_q + t_q)
            || (cy + t_q > ymax_q);
    x_inner  = (nx >= xmin_q + t_q)
            && (nx + t_q <= xmax_q);
    cand     = nx;
    if (!row_full && x_inner)
      cand = xmax_q + crd_t'(1) - t_q;
    row_cont = (cand <= cxmax_q);
    last     = !row_cont && (ny > cymax_q);
    xfer     = bus.pixel_valid && bus.pixel_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = SETUP;
      SETUP: state_d = s_off ? DONE : DRAW;
      DRAW:  if (xfer && last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.px          <= '0;
      bus.py          <= '0;
      bus.pixel_color <= '0;
      bus.pixel_valid <= 1'b0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.clipped     <= 1'b0;
      rx0     <= '0;
      ry0     <= '0;
      rx1     <= '0;
      ry1     <= '0;
      r_thick <= '0;
      r_fill  <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cxmax_q <= '0;
      cymax_q <= '0;
      t_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          rx0     <= bus.x0;
          ry0     <= bus.y0;
          rx1     <= bus.x1;
          ry1     <= bus.y1;
          r_thick <= bus.thick;
          r_fill  <= bus.fill_enable;
          bus.pixel_color <= bus.color;
          bus.busy        <= 1'b1;
          bus.clipped     <= 1'b0;
        end
        SETUP: begin
          xmin_q  <= s_xmin;
          xmax_q  <= s_xmax;
          ymin_q  <= s_ymin;
          ymax_q  <= s_ymax;
          cxmax_q <= s_cx;
          cymax_q <= s_cy;
          t_q     <= s_t;
          bus.clipped <= s_clip;
          if (s_off) begin
            bus.done <= 1'b1;
          end else begin
            bus.px          <= s_xmin[CW-1:0];
            bus.py          <= s_ymin[CW-1:0];
            bus.pixel_valid <= 1'b1;
          end
        end
        DRAW: if (xfer) begin
          if (last) begin
            bus.pixel_valid <= 1'b0;
            bus.done        <= 1'b1;
          end else if (row_cont) begin
            bus.px <= cand[CW-1:0];
          end else begin
            bus.px <= xmin_q[CW-1:0];
            bus.py <= ny[CW-1:0];
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rect_draw_clip.sv
// Self-checking bench for rect_draw_clip.
// Expected pixel lists come from a plain nested-loop model of the drawing rules.
module tb_rect_draw_clip;
  localparam int CW    = 8;
  localparam int COLW  = 24;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rect_draw_clip_if #(.CW(CW), .COLW(COLW)) bus ();

  rect_draw_clip #(
    .CW(CW), .COLW(COLW), .SCR_W(SCR_W), .SCR_H(SCR_H)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {int x; int y;} pix_t;

  int   checks = 0;
  int   errors = 0;
  pix_t expq[$];
  bit   exp_clip;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_model(int ax, int ay, int bx, int by,
                             bit fill, int th);
    int xmin, xmax, ymin, ymax, t;
    xmin = (ax < bx) ? ax : bx;
    xmax = (ax < bx) ? bx : ax;
    ymin = (ay < by) ? ay : by;
    ymax = (ay < by) ? by : ay;
    t = (th == 0) ? 1 : th;
    expq.delete();
    exp_clip = (xmax > SCR_W - 1) || (ymax > SCR_H - 1);
    for (int y = ymin; y <= ymax && y < SCR_H; y++)
      for (int x = xmin; x <= xmax && x < SCR_W; x++)
        if (fill || x < xmin + t || x > xmax - t
            || y < ymin + t || y > ymax - t)
          expq.push_back('{x: x, y: y});
  endtask

  task automatic check_zero(string tag);
    chk({tag, ":px"}, bus.px, 0);
    chk({tag, ":py"}, bus.py, 0);
    chk({tag, ":col"}, bus.pixel_color, 0);
    chk({tag, ":valid"}, bus.pixel_valid, 0);
    chk({tag, ":done"}, bus.done, 0);
    chk({tag, ":busy"}, bus.busy, 0);
    chk({tag, ":clipped"}, bus.clipped, 0);
  endtask

  task automatic drive_req(int ax, int ay, int bx, int by, bit fill,
                           int th, logic [COLW-1:0] col);
    bus.x0 = CW'(ax);
    bus.y0 = CW'(ay);
    bus.x1 = CW'(bx);
    bus.y1 = CW'(by);
    bus.fill_enable = fill;
    bus.thick = 4'(th);
    bus.color = col;
    bus.start = 1'b1;
  endtask

  task automatic run_rect(string tag, int ax, int ay, int bx, int by,
                          bit fill, int th, logic [COLW-1:0] col,
                          bit rnd_ready, bit poke);
    int k, n, got;
    bit seen_done, stalled;
    logic [CW-1:0] lpx, lpy;
    logic [COLW-1:0] lcol;
    pix_t p;
    build_model(ax, ay, bx, by, fill, th);
    n = expq.size();
    drive_req(ax, ay, bx, by, fill, th, col);
    bus.pixel_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, ":busy"}, bus.busy, 1);
    k = 0; got = 0; seen_done = 0; stalled = 0;
    lpx = '0; lpy = '0; lcol = '0;
    while (!seen_done && k < 4000) begin
      tick();
      k++;
      if (poke && k == 4) drive_req(0, 0, 50, 50, 1, 0, 24'hABCDEF);
      else bus.start = 1'b0;
      bus.pixel_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == 1) chk({tag, ":first_valid"}, bus.pixel_valid, n != 0);
      if (stalled) begin
        chk({tag, ":hold_valid"}, bus.pixel_valid, 1);
        chk({tag, ":hold_px"}, bus.px, lpx);
        chk({tag, ":hold_py"}, bus.py, lpy);
        chk({tag, ":hold_col"}, bus.pixel_color, lcol);
      end
      stalled = 0;
      if (bus.done) begin
        seen_done = 1;
        chk({tag, ":valid_at_done"}, bus.pixel_valid, 0);
      end else if (bus.pixel_valid) begin
        lpx = bus.px; lpy = bus.py; lcol = bus.pixel_color;
        if (bus.pixel_ready) begin
          if (expq.size() == 0) begin
            chk({tag, ":extra_pixel"}, got + 1, n);
          end else begin
            p = expq.pop_front();
            chk({tag, ":px"}, bus.px, p.x);
            chk({tag, ":py"}, bus.py, p.y);
            chk({tag, ":col"}, bus.pixel_color, col);
          end
          got++;
        end else begin
          stalled = 1;
        end
      end
    end
    bus.start = 1'b0;
    chk({tag, ":done_seen"}, seen_done, 1);
    if (!rnd_ready) chk({tag, ":done_cycle"}, k, n + 1);
    chk({tag, ":count"}, got, n);
    chk({tag, ":clipped"}, bus.clipped, exp_clip);
    bus.pixel_ready = 1'b1;
    tick();
    chk({tag, ":done_pulse"}, bus.done, 0);
    chk({tag, ":idle"}, bus.busy, 0);
    chk({tag, ":clip_hold"}, bus.clipped, exp_clip);
  endtask

  initial begin
    bit bad;
    int ax, ay, bx, by;
    bus.start = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.fill_enable = 1'b0;
    bus.thick = '0;
    bus.color = '0;
    bus.pixel_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    run_rect("fill",   10, 10, 14, 12, 1, 0, 24'h0000FF, 0, 0);
    run_rect("swap",   14, 12, 10, 10, 1, 0, 24'h0000FF, 0, 0);
    run_rect("out1",   10, 10, 14, 13, 0, 1, 24'h00FF00, 0, 0);
    run_rect("out3",   10, 10, 14, 13, 0, 3, 24'hFF0000, 0, 0);
    run_rect("out0",   10, 10, 14, 13, 0, 0, 24'h123456, 0, 0);
    run_rect("clipf", 150,  5, 200,  6, 1, 1, 24'h777777, 0, 0);
    run_rect("clipo", 150,  5, 200,  8, 0, 1, 24'h888888, 0, 0);
    run_rect("corner",155,115, 159,119, 0, 2, 24'h010203, 0, 0);
    run_rect("clipy",  20,110,  26,140, 0, 2, 24'h0F0F0F, 0, 0);
    run_rect("dot",     5,  5,   5,  5, 0, 2, 24'hC0FFEE, 0, 0);
    run_rect("hline",  20,  7,   3,  7, 0, 1, 24'h00AA00, 0, 0);
    run_rect("vline",  30,  2,  30,  9, 0, 4, 24'h00BB00, 0, 0);
    run_rect("rdy",    10, 10,  14, 12, 1, 0, 24'h0000FF, 1, 1);
    run_rect("off",   200, 10, 210, 20, 1, 0, 24'hFFFFFF, 0, 0);

    for (int i = 0; i < 8; i++) begin
      ax = $urandom_range(0, 170);
      ay = $urandom_range(0, 130);
      bx = ax + $urandom_range(0, 24) - 8;
      by = ay + $urandom_range(0, 24) - 8;
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      if (bx > 255) bx = 255;
      if (by > 255) by = 255;
      run_rect($sformatf("rnd%0d", i), ax, ay, bx, by,
               1'($urandom_range(0, 1)), $urandom_range(0, 15),
               COLW'($urandom), 1'($urandom_range(0, 1)), 0);
    end

    drive_req(10, 10, 14, 12, 1, 0, 24'h0000FF);
    bus.pixel_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("mid:valid_before_rst", bus.pixel_valid, 1);
    rst_n = 1'b0;
    drive_req(20, 20, 22, 22, 1, 0, 24'h00FF00);
    tick();
    check_zero("mid_rst");
    rst_n = 1'b1;
    bus.start = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done || bus.pixel_valid || bus.busy) bad = 1;
    end
    chk("mid:quiet_after_rst", bad, 0);
    run_rect("recover", 14, 12, 10, 10, 0, 1, 24'h0000FF, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
